// File: rtl/router_pkg.sv
// Shared router definitions: flit field positions, port direction codes and
// the credit flit builder used by every link port.
package router_pkg;

    localparam int FLIT_SIZE      = 82;
    localparam int VALID_BIT      = 81;
    localparam int CREDIT_BIT     = 80;
    localparam int CREDIT_LSB     = 0;
    localparam int CREDIT_MSB     = 7;
    localparam int CREDIT_FIELD_W = CREDIT_MSB - CREDIT_LSB + 1;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    typedef logic [FLIT_SIZE-1:0] flit_t;

    function automatic flit_t make_credit_flit(input logic [CREDIT_FIELD_W-1:0] count);
        flit_t f;
        f                        = '0;
        f[VALID_BIT]             = 1'b1;
        f[CREDIT_BIT]            = 1'b1;
        f[CREDIT_MSB:CREDIT_LSB] = count;
        return f;
    endfunction

endpackage

// File: rtl/tx_inject_fifo.sv
// Show-ahead synchronous FIFO buffering locally injected flits until the
// output arbiter grants them.
module tx_inject_fifo #(
    parameter int DW = 82,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   usedw_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   used_q;
    logic          do_push, do_pop;

    assign empty_o = (used_q == '0);
    assign full_o  = used_q[AW];
    assign usedw_o = used_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted when a pop frees a slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   used_q <= used_q + 1'b1;
                2'b01:   used_q <= used_q - 1'b1;
                default: used_q <= used_q;
            endcase
        end
    end

endmodule

// File: rtl/output_port_tx.sv
// Transmit side of a router link port: merges switch and inject traffic onto the
// MGT output under downstream credit control and returns freed local credits.
module output_port_tx
    import router_pkg::*;
#(
    parameter int INIT_CREDIT        = 32,
    parameter int CREDIT_W           = 8,
    parameter int INJ_Q_AW           = 4,
    parameter int CREDIT_BACK_PERIOD = 100,
    parameter int CREDIT_THRESHOLD   = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] sw_flit,
    input  logic                 sw_valid,
    output logic                 sw_grant,
    input  logic [FLIT_SIZE-1:0] inject_flit,
    input  logic                 inject_valid,
    output logic                 inject_avail,
    input  logic [FLIT_SIZE-1:0] credit_in,
    input  logic                 credit_in_valid,
    input  logic                 local_consume,
    output logic [FLIT_SIZE-1:0] out_flit,
    output logic                 out_valid,
    output logic [CREDIT_W-1:0]  credit_count,
    output logic                 credit_overflow
);

    localparam int PER_W = (CREDIT_BACK_PERIOD > 1) ? $clog2(CREDIT_BACK_PERIOD) : 1;
    localparam int SUM_W = CREDIT_W + 2;

    logic [PER_W-1:0]     per_q, per_d;
    logic [CREDIT_W-1:0]  acc_q, acc_d;
    logic [CREDIT_W-1:0]  cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rr_q, rr_d;
    logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
    logic                 out_valid_q, out_valid_d;

    logic                 fifo_full, fifo_empty;
    logic [FLIT_SIZE-1:0] fifo_rdata;
    logic [INJ_Q_AW:0]    unused_inj_usedw;
    logic                 unused_cin;

    logic                 per_wrap, credit_due, data_ok;
    logic                 req_sw, req_inj, grant_sw, grant_inj;
    logic [SUM_W-1:0]     ret_amt, cnt_sum;

    assign unused_cin = ^{credit_in[FLIT_SIZE-1:CREDIT_BIT+1], credit_in[CREDIT_BIT-1:CREDIT_MSB+1]};

    tx_inject_fifo #(
        .DW (FLIT_SIZE),
        .AW (INJ_Q_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (inject_valid && !fifo_full),
        .wdata_i (inject_flit),
        .pop_i   (grant_inj),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usedw_o (unused_inj_usedw)
    );

    // rr_q = 0 favours the switch, 1 favours the inject FIFO.
    always_comb begin
        per_wrap   = (per_q == PER_W'(CREDIT_BACK_PERIOD - 1));
        credit_due = (per_wrap && (acc_q != '0)) || (acc_q >= CREDIT_W'(CREDIT_THRESHOLD));
        data_ok    = !credit_due && (cnt_q != '0);
        req_sw     = data_ok && sw_valid;
        req_inj    = data_ok && !fifo_empty;
        grant_sw   = req_sw && (!req_inj || !rr_q);
        grant_inj  = req_inj && (!req_sw || rr_q);
    end

    assign sw_grant     = grant_sw;
    assign inject_avail = !fifo_full;

    always_comb begin
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        rr_d        = rr_q;
        if (credit_due) begin
            out_valid_d = 1'b1;
            out_flit_d  = make_credit_flit(CREDIT_FIELD_W'(acc_q));
        end else if (grant_sw) begin
            out_valid_d = 1'b1;
            out_flit_d  = sw_flit;
            rr_d        = 1'b1;
        end else if (grant_inj) begin
            out_valid_d = 1'b1;
            out_flit_d  = fifo_rdata;
            rr_d        = 1'b0;
        end
    end

    // The period counter free-runs; a threshold-forced return does not realign it.
    always_comb begin
        per_d = per_wrap ? '0 : per_q + PER_W'(1);
        acc_d = acc_q;
        if (credit_due) begin
            acc_d = CREDIT_W'(local_consume);
        end else if (local_consume && (acc_q != '1)) begin
            acc_d = acc_q + CREDIT_W'(1);
        end
    end

    always_comb begin
        ret_amt = (credit_in_valid && credit_in[CREDIT_BIT])
                ? SUM_W'(credit_in[CREDIT_MSB:CREDIT_LSB]) : '0;
        cnt_sum = SUM_W'(cnt_q) - SUM_W'(grant_sw || grant_inj) + ret_amt;
        cnt_d   = cnt_sum[CREDIT_W-1:0];
        ovf_d   = ovf_q;
        if (cnt_sum > SUM_W'(INIT_CREDIT)) begin
            cnt_d = CREDIT_W'(INIT_CREDIT);
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= CREDIT_W'(INIT_CREDIT);
            ovf_q       <= 1'b0;
            rr_q        <= 1'b0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            per_q       <= per_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            rr_q        <= rr_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_flit        = out_flit_q;
    assign out_valid       = out_valid_q;
    assign credit_count    = cnt_q;
    assign credit_overflow = ovf_q;

endmodule

// File: tb/tb_output_port_tx.sv
// Bench for output_port_tx: random flit payloads checked cycle by cycle against
// a queue-based model of the port, plus directed checks of the key behaviours.
`timescale 1ns/1ps
module tb_output_port_tx;

    localparam int FW = 82;

    logic          clk;
    logic          rst;
    logic [FW-1:0] sw_flit, inject_flit, credit_in, out_flit;
    logic          sw_valid, sw_grant, inject_valid, inject_avail;
    logic          credit_in_valid, local_consume, out_valid, credit_overflow;
    logic [7:0]    credit_count;

    logic          t_lc, t_sw_grant, t_inject_avail, t_out_valid, t_ovf;
    logic [FW-1:0] t_out_flit;
    logic [7:0]    t_credit_count;

    int total = 0;
    int bad   = 0;

    // model state
    int            m_cred, m_acc, m_per;
    bit            m_pri_inj, m_valid, m_ovf;
    logic [FW-1:0] m_flit;
    logic [FW-1:0] m_q[$];

    bit            exp_grant, exp_avail, act_grant, act_avail;
    logic [93:0]   act_vec, exp_vec;

    output_port_tx dut (
        .clk(clk), .rst(rst),
        .sw_flit(sw_flit), .sw_valid(sw_valid), .sw_grant(sw_grant),
        .inject_flit(inject_flit), .inject_valid(inject_valid), .inject_avail(inject_avail),
        .credit_in(credit_in), .credit_in_valid(credit_in_valid), .local_consume(local_consume),
        .out_flit(out_flit), .out_valid(out_valid),
        .credit_count(credit_count), .credit_overflow(credit_overflow)
    );

    // Longer return period so the accumulation threshold can be reached before a wrap.
    output_port_tx #(.CREDIT_BACK_PERIOD(256)) dut_thr (
        .clk(clk), .rst(rst),
        .sw_flit({FW{1'b0}}), .sw_valid(1'b0), .sw_grant(t_sw_grant),
        .inject_flit({FW{1'b0}}), .inject_valid(1'b0), .inject_avail(t_inject_avail),
        .credit_in({FW{1'b0}}), .credit_in_valid(1'b0), .local_consume(t_lc),
        .out_flit(t_out_flit), .out_valid(t_out_valid),
        .credit_count(t_credit_count), .credit_overflow(t_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [FW-1:0] rnd_flit();
        return {1'b1, 1'b0, 16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [FW-1:0] cred_flit(input int n);
        return (FW'(3) << 80) | FW'(n);
    endfunction

    function automatic void m_reset();
        m_cred = 32; m_acc = 0; m_per = 0; m_pri_inj = 0;
        m_valid = 0; m_ovf = 0; m_flit = '0;
        m_q.delete();
    endfunction

    function automatic void model_step();
        bit due, g_sw, g_inj, full;
        int ret;
        full = (m_q.size() >= 16);
        due  = (m_per == 99 && m_acc > 0) || (m_acc >= 160);
        g_sw = 0; g_inj = 0;
        if (!due && m_cred > 0) begin
            if (sw_valid && m_q.size() > 0) begin
                if (m_pri_inj) g_inj = 1; else g_sw = 1;
            end else if (sw_valid) g_sw = 1;
            else if (m_q.size() > 0) g_inj = 1;
        end
        exp_grant = g_sw;
        exp_avail = !full;
        m_valid = due || g_sw || g_inj;
        if (due) m_flit = cred_flit(m_acc);
        else if (g_sw) m_flit = sw_flit;
        else if (g_inj) m_flit = m_q[0];
        if (g_sw) m_pri_inj = 1;
        if (g_inj) begin m_pri_inj = 0; void'(m_q.pop_front()); end
        if (inject_valid && !full) m_q.push_back(inject_flit);
        ret = (credit_in_valid && credit_in[80]) ? int'(credit_in[7:0]) : 0;
        m_cred = m_cred - ((g_sw || g_inj) ? 1 : 0) + ret;
        if (m_cred > 32) begin m_cred = 32; m_ovf = 1; end
        if (due) m_acc = local_consume ? 1 : 0;
        else if (local_consume && m_acc < 255) m_acc++;
        m_per = (m_per + 1) % 100;
    endfunction

    task automatic idle();
        sw_valid = 0; sw_flit = '0; inject_valid = 0; inject_flit = '0;
        credit_in_valid = 0; credit_in = '0; local_consume = 0;
    endtask

    // Inputs are set at posedge+1; comb outputs sampled at +2, registered at next posedge+1.
    task automatic cycle();
        #1;
        act_grant = sw_grant;
        act_avail = inject_avail;
        model_step();
        @(posedge clk);
        #1;
        act_vec = {act_grant, act_avail, out_valid, credit_overflow, credit_count, out_flit};
        exp_vec = {exp_grant, exp_avail, m_valid, m_ovf, 8'(m_cred), m_flit};
    endtask

    task automatic test_reset();
        idle(); t_lc = 0; rst = 0; m_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || out_flit !== '0) begin bad++;
            $display("FAIL reset_out got v=%b f=%h want v=0 f=0", out_valid, out_flit); end
        total++; if (credit_count !== 8'd32) begin bad++;
            $display("FAIL reset_credit got %0d want 32", credit_count); end
        total++; if ({credit_overflow, inject_avail, sw_grant} !== 3'b010) begin bad++;
            $display("FAIL reset_flags got %b want 010", {credit_overflow, inject_avail, sw_grant}); end
        total++; if ({t_credit_count, t_ovf, t_inject_avail, t_sw_grant, t_out_valid} !== {8'd32, 4'b0100}) begin bad++;
            $display("FAIL reset_thr got %h", {t_credit_count, t_ovf, t_inject_avail, t_sw_grant, t_out_valid}); end
        rst = 1;
    endtask

    task automatic test_burst();
        int n_out = 0, late_grant = 0, lat_err = 0;
        bit prev_grant = 0;
        idle();
        sw_valid = 1;
        for (int i = 0; i < 40; i++) begin
            sw_flit = rnd_flit();
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL burst cyc=%0d got %h want %h", i, act_vec, exp_vec); end
            if (out_valid) n_out++;
            if (i >= 32 && act_grant) late_grant++;
            if (out_valid !== act_grant) lat_err++;
            prev_grant = act_grant;
        end
        total++; if (n_out != 32) begin bad++; $display("FAIL burst_count got %0d want 32", n_out); end
        total++; if (credit_count !== 8'd0) begin bad++; $display("FAIL burst_credit got %0d want 0", credit_count); end
        total++; if (late_grant != 0) begin bad++; $display("FAIL burst_late_grant got %0d want 0", late_grant); end
        total++; if (lat_err != 0) begin bad++; $display("FAIL burst_latency got %0d errs want 0", lat_err); end
    endtask

    task automatic test_credit_return();
        int n_out = 0;
        idle();
        sw_valid = 1; sw_flit = rnd_flit();
        credit_in_valid = 1; credit_in = (FW'($urandom) << 8) | FW'(7);
        credit_in[80] = 1'b0;
        cycle();
        total++; if (credit_count !== 8'd0) begin bad++;
            $display("FAIL ignore_non_credit got %0d want 0", credit_count); end
        credit_in = cred_flit(5);
        for (int i = 0; i < 11; i++) begin
            cycle();
            credit_in_valid = 0;
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL ret cyc=%0d got %h want %h", i, act_vec, exp_vec); end
            if (out_valid) n_out++;
            sw_flit = rnd_flit();
        end
        total++; if (n_out != 5) begin bad++; $display("FAIL ret_count got %0d want 5", n_out); end
        total++; if (credit_count !== 8'd0) begin bad++; $display("FAIL ret_credit got %0d want 0", credit_count); end
        sw_valid = 0;
    endtask

    task automatic test_alternate();
        int toggle_err = 0, occ_err = 0;
        bit prev = 0;
        idle();
        for (int i = 0; i < 16; i++) begin
            inject_valid = 1; inject_flit = rnd_flit();
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL fill cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
        inject_valid = 0;
        total++; if (inject_avail !== 1'b0) begin bad++; $display("FAIL fifo_full got avail=%b want 0", inject_avail); end
        credit_in_valid = 1; credit_in = cred_flit(32);
        sw_valid = 1; sw_flit = rnd_flit();
        cycle();
        credit_in_valid = 0;
        for (int i = 0; i < 16; i++) begin
            sw_flit = rnd_flit();
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL alt cyc=%0d got %h want %h", i, act_vec, exp_vec); end
            if (i > 0 && act_grant == prev) toggle_err++;
            if (int'(dut.u_fifo.usedw_o) != m_q.size() || int'(dut.u_fifo.usedw_o) != 16 - (i + 2) / 2) occ_err++;
            prev = act_grant;
        end
        total++; if (toggle_err != 0) begin bad++; $display("FAIL alt_toggle got %0d errs want 0", toggle_err); end
        total++; if (occ_err != 0) begin bad++; $display("FAIL alt_occupancy got %0d errs want 0", occ_err); end
        sw_valid = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL drain cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
    endtask

    task automatic test_periodic();
        logic [FW-1:0] held;
        int n_cred = 0, after = 0;
        bit wrapped = 0, wrap_now;
        idle();
        for (int i = 0; i < 100 && m_per > 80; i++) begin
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL per_align cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
        for (int i = 0; i < 6; i++) begin
            local_consume = (i % 2 == 0);
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL per_consume cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
        local_consume = 0;
        held = rnd_flit(); sw_flit = held;
        for (int i = 0; i < 120 && after < 3; i++) begin
            wrap_now = (m_per == 99);
            sw_valid = wrap_now || wrapped;
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL per cyc=%0d got %h want %h", i, act_vec, exp_vec); end
            if (out_valid && out_flit[80]) n_cred++;
            if (wrap_now) begin
                wrapped = 1;
                total++; if (act_grant !== 1'b0) begin bad++; $display("FAIL per_grant_blocked got %b want 0", act_grant); end
                total++; if (out_valid !== 1'b1 || out_flit !== cred_flit(3)) begin bad++;
                    $display("FAIL per_credit_flit got v=%b f=%h want %h", out_valid, out_flit, cred_flit(3)); end
            end else if (wrapped) begin
                after++;
                if (after == 1) begin
                    total++; if (out_valid !== 1'b1 || out_flit !== held) begin bad++;
                        $display("FAIL per_delayed_data got v=%b f=%h want %h", out_valid, out_flit, held); end
                end
            end
        end
        sw_valid = 0;
        total++; if (n_cred != 1) begin bad++; $display("FAIL per_credit_count got %0d want 1", n_cred); end
    endtask

    task automatic test_overflow();
        idle();
        credit_in_valid = 1; credit_in = cred_flit(32 - m_cred);
        cycle();
        credit_in_valid = 0;
        sw_valid = 1;
        for (int i = 0; i < 2; i++) begin
            sw_flit = rnd_flit();
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL ovf_send cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
        sw_valid = 0;
        total++; if (credit_count !== 8'd30) begin bad++; $display("FAIL ovf_pre got %0d want 30", credit_count); end
        credit_in_valid = 1; credit_in = cred_flit(10);
        cycle();
        credit_in_valid = 0;
        total++; if (credit_count !== 8'd32 || credit_overflow !== 1'b1) begin bad++;
            $display("FAIL ovf_clamp got cnt=%0d ovf=%b want 32/1", credit_count, credit_overflow); end
        repeat (3) cycle();
        total++; if (act_vec !== exp_vec || credit_overflow !== 1'b1) begin bad++;
            $display("FAIL ovf_sticky got %h want %h", act_vec, exp_vec); end
    endtask

    task automatic test_reset_mid();
        idle();
        sw_valid = 1;
        for (int i = 0; i < 60; i++) begin
            sw_flit = rnd_flit();
            inject_valid = (m_q.size() < 16);
            inject_flit = rnd_flit();
            cycle();
            total++; if (act_vec !== exp_vec) begin bad++;
                $display("FAIL mid cyc=%0d got %h want %h", i, act_vec, exp_vec); end
        end
        total++; if (inject_avail !== 1'b0) begin bad++; $display("FAIL mid_full got avail=%b want 0", inject_avail); end
        #2;
        rst = 0;
        #1;
        total++; if (out_valid !== 1'b0 || out_flit !== '0) begin bad++;
            $display("FAIL mid_reset_out got v=%b f=%h want 0", out_valid, out_flit); end
        total++; if (credit_count !== 8'd32 || credit_overflow !== 1'b0 || inject_avail !== 1'b1) begin bad++;
            $display("FAIL mid_reset_state got cnt=%0d ovf=%b avail=%b want 32/0/1",
                     credit_count, credit_overflow, inject_avail); end
        idle(); m_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_threshold();
        int first = -1;
        logic [FW-1:0] got = '0;
        t_lc = 1;
        for (int n = 1; n <= 200 && first < 0; n++) begin
            @(posedge clk);
            #1;
            if (t_out_valid) begin first = n; got = t_out_flit; end
        end
        t_lc = 0;
        total++; if (first != 161) begin bad++; $display("FAIL thr_timing got cycle %0d want 161", first); end
        total++; if (got !== cred_flit(160)) begin bad++;
            $display("FAIL thr_flit got %h want %h", got, cred_flit(160)); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_credit_return();
        test_alternate();
        test_periodic();
        test_overflow();
        test_reset_mid();
        test_threshold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
